// File: rtl/cpu_pkg.sv
// Shared definitions for the stack-based CPU: default word and stack sizes
// plus the one-hot command decode used by the operand stack.
package cpu_pkg;

  localparam int WORD_W      = 8;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH    = 3'd1,
    POP     = 3'd2,
    TOS     = 3'd3,
    ILLEGAL = 3'd4
  } stack_cmd_e;

  // Any combination with more than one strobe raised collapses to ILLEGAL.
  function automatic stack_cmd_e decode_cmd(input logic push_i, input logic pop_i, input logic tos_i);
    stack_cmd_e cmd;
    case ({push_i, pop_i, tos_i})
      3'b000:  cmd = IDLE;
      3'b100:  cmd = PUSH;
      3'b010:  cmd = POP;
      3'b001:  cmd = TOS;
      default: cmd = ILLEGAL;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Operand stack storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the pointer logic keeps stale entries hidden.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack: decodes push/pop/tos, owns the stack pointer,
// the registered read port and the sticky ovf/udf/cmd_err flags.
module stack_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf,
  output logic             cmd_err
);

  localparam int AW = $clog2(DEPTH);

  stack_cmd_e       cmd_s;
  logic [CW-1:0]    sp_r, sp_nxt_s;
  logic [WIDTH-1:0] d_out_r, d_out_nxt_s, rd_data_s;
  logic             d_valid_r, d_valid_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             udf_r, udf_nxt_s;
  logic             cmd_err_r, cmd_err_nxt_s;
  logic             we_s, full_s, empty_s;
  logic [AW-1:0]    wr_addr_s, rd_addr_s;

  assign cmd_s   = decode_cmd(push, pop, tos);
  assign full_s  = (sp_r == CW'(DEPTH));
  assign empty_s = (sp_r == {CW{1'b0}});

  // The write slot is sp and the top entry is sp-1; saturation is handled by
  // full/empty, so the truncated addresses are only used when in range.
  assign wr_addr_s = AW'(sp_r);
  assign rd_addr_s = AW'(sp_r - CW'(1));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_addr_s),
    .wdata (d_in),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Command decode and next-state selection
  always_comb begin
    sp_nxt_s      = sp_r;
    d_out_nxt_s   = d_out_r;
    d_valid_nxt_s = 1'b0;
    ovf_nxt_s     = ovf_r;
    udf_nxt_s     = udf_r;
    cmd_err_nxt_s = cmd_err_r;
    we_s          = 1'b0;
    case (cmd_s)
      IDLE: begin
        sp_nxt_s = sp_r;
      end
      PUSH: begin
        if (full_s) begin
          ovf_nxt_s = 1'b1;
        end else begin
          we_s     = 1'b1;
          sp_nxt_s = sp_r + CW'(1);
        end
      end
      POP: begin
        if (empty_s) begin
          udf_nxt_s = 1'b1;
        end else begin
          d_out_nxt_s   = rd_data_s;
          d_valid_nxt_s = 1'b1;
          sp_nxt_s      = sp_r - CW'(1);
        end
      end
      TOS: begin
        if (empty_s) begin
          udf_nxt_s = 1'b1;
        end else begin
          d_out_nxt_s   = rd_data_s;
          d_valid_nxt_s = 1'b1;
        end
      end
      ILLEGAL: begin
        cmd_err_nxt_s = 1'b1;
      end
      default: begin
        cmd_err_nxt_s = 1'b1;
      end
    endcase
  end

  // State, read data and sticky flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_r      <= {CW{1'b0}};
      d_out_r   <= {WIDTH{1'b0}};
      d_valid_r <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      sp_r      <= sp_nxt_s;
      d_out_r   <= d_out_nxt_s;
      d_valid_r <= d_valid_nxt_s;
      ovf_r     <= ovf_nxt_s;
      udf_r     <= udf_nxt_s;
      cmd_err_r <= cmd_err_nxt_s;
    end
  end

  assign d_out   = d_out_r;
  assign d_valid = d_valid_r;
  assign count   = sp_r;
  assign full    = full_s;
  assign empty   = empty_s;
  assign ovf     = ovf_r;
  assign udf     = udf_r;
  assign cmd_err = cmd_err_r;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: a behavioural LIFO model predicts each
// read; expected words queue up at drive time and are consumed on d_valid.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, tos;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, udf, cmd_err;

  logic [WIDTH-1:0] mstk[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             m_ovf, m_udf, m_cmd_err;
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .d_in    (d_in),
    .d_out   (d_out),
    .d_valid (d_valid),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf),
    .cmd_err (cmd_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_state(input logic exp_valid);
    check("d_valid", 32'(d_valid), 32'(exp_valid));
    if (d_valid) begin
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) exp_dout = sb_q.pop_front();
    end else if (exp_valid && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    check("d_out",   32'(d_out),   32'(exp_dout));
    check("count",   32'(count),   32'(mstk.size()));
    check("full",    32'(full),    32'(mstk.size() == DEPTH));
    check("empty",   32'(empty),   32'(mstk.size() == 0));
    check("ovf",     32'(ovf),     32'(m_ovf));
    check("udf",     32'(udf),     32'(m_udf));
    check("cmd_err", 32'(cmd_err), 32'(m_cmd_err));
  endtask

  // Drive one command cycle, update the model, then check after the edge.
  task automatic step(input logic p, input logic o, input logic t, input logic [WIDTH-1:0] d);
    int   n;
    logic ev;
    ev  = 1'b0;
    n   = int'(p) + int'(o) + int'(t);
    rst = 1'b1; push = p; pop = o; tos = t; d_in = d;
    if (n > 1) begin
      m_cmd_err = 1'b1;
    end else if (p) begin
      if (mstk.size() == DEPTH) m_ovf = 1'b1;
      else mstk.push_back(d);
    end else if (o || t) begin
      if (mstk.size() == 0) begin
        m_udf = 1'b1;
      end else begin
        ev = 1'b1;
        sb_q.push_back(mstk[$]);
        if (o) void'(mstk.pop_back());
      end
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0;
    check_state(ev);
  endtask

  // Hold rst low for some cycles while optionally presenting a command.
  task automatic reset_with(input int cycles, input logic p, input logic o, input logic t);
    rst = 1'b0; push = p; pop = o; tos = t; d_in = 8'hEE;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0;
    mstk.delete();
    sb_q.delete();
    exp_dout  = '0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    m_cmd_err = 1'b0;
    check_state(1'b0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; d_in = '0;
    exp_dout = '0; m_ovf = 1'b0; m_udf = 1'b0; m_cmd_err = 1'b0;
    @(negedge clk);

    // Reset then pop on empty
    reset_with(2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    // LIFO order
    reset_with(1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 8'h22);
    step(1'b1, 1'b0, 1'b0, 8'h33);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Fill and overflow
    reset_with(1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // tos is non-destructive
    reset_with(1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Illegal push+pop leaves the stack alone
    reset_with(1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h44);
    step(1'b1, 1'b1, 1'b0, 8'h99);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Reset wins over a pop mid-operation
    reset_with(1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 1'b0, 8'hA3);
    reset_with(1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h07);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Randomised mix, including idle cycles and saturation at both ends
    reset_with(1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [WIDTH-1:0] d;
      r = $urandom_range(0, 19);
      d = WIDTH'($urandom);
      if (r < 8)       step(1'b1, 1'b0, 1'b0, d);
      else if (r < 14) step(1'b0, 1'b1, 1'b0, d);
      else if (r < 17) step(1'b0, 1'b0, 1'b1, d);
      else if (r < 19) step(1'b0, 1'b0, 1'b0, d);
      else             step(1'b0, 1'b1, 1'b1, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the stack-based CPU: the responder to the controller's `push` / `pop` / `tos` strobes. It stores words written by the datapath and returns the top entry on a registered read port. It sits beside the datapath, fed by `st_data`-selected write data, and tracks full/empty with sticky overflow/underflow error flags.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 8: number of stack entries; any value ≥ 2.
- `CW`, `$clog2(DEPTH+1)`: occupancy counter width (derived, not overridden).

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `push`  input  1  write `d_in` onto the stack this cycle.
- `pop`  input  1  remove the top entry and present it on `d_out`.
- `tos`  input  1  present the top entry on `d_out` without removing it.
- `d_in`  input  WIDTH  write data for `push`.
- `d_out`  output  WIDTH  registered read data.
- `d_valid`  output  1  one-cycle pulse; `d_out` was updated by a legal pop/tos.
- `count`  output  CW  current number of stored entries.
- `full`  output  1  `count == DEPTH`.
- `empty`  output  1  `count == 0`.
- `ovf`  output  1  sticky: a push was attempted while full.
- `udf`  output  1  sticky: a pop or tos was attempted while empty.
- `cmd_err`  output  1  sticky: more than one of `push` / `pop` / `tos` was asserted in the same cycle.

## Operation
- Storage: DEPTH × WIDTH register array. The stack pointer `sp` equals `count`. The top entry is at index `sp-1`.
- Command decode per cycle is one-hot over {`push`, `pop`, `tos`}:
  - **None asserted:** idle. All state holds and `d_valid` = 0.
  - **push, not full:** `mem[sp] <= d_in`, then `sp <= sp+1`.
  - **push, full:** no write and no pointer change. `ovf <= 1`.
  - **pop, not empty:** `d_out <= mem[sp-1]`, `sp <= sp-1`, `d_valid <= 1`.
  - **pop, empty:** `d_out` holds, `sp` holds, `udf <= 1`, `d_valid` = 0.
  - **tos, not empty:** `d_out <= mem[sp-1]`, `sp` unchanged, `d_valid <= 1`.
  - **tos, empty:** same as pop-on-empty, with `udf <= 1`.
  - **Two or more asserted:** no storage, pointer or `d_out` change. `cmd_err <= 1`, `d_valid` = 0.
- Popped array entries are not cleared. Stale data is never observable through `d_out`.
- `ovf`, `udf` and `cmd_err` clear only on reset. The stack continues operating after an error.
- `full`, `empty` and `count` are combinational from `sp`.

## Timing
- Reset (`rst` == 0 at a rising edge) forces: `sp` = 0, `d_out` = 0, `d_valid` = 0, `ovf` = `udf` = `cmd_err` = 0. Resulting outputs are `count` = 0, `empty` = 1, `full` = 0.
- Reset wins over any command in the same cycle. The array contents are not reset.
- Latency:
  - pop/tos to `d_out` / `d_valid`: 1 cycle.
  - push to visible `count`: 1 cycle.
  - push followed by tos on the next cycle returns the pushed word.
- Back-to-back commands are legal every cycle with no bubbles.
- Wrap-around: `sp` never exceeds DEPTH or goes below 0. Saturation is enforced by the full/empty checks, not by modulo arithmetic.
- `d_out` holds its last value until the next legal pop/tos.

## Structure
- Shared package `cpu_pkg`:
  - `WORD_W` (default for WIDTH).
  - `STACK_DEPTH` (default for DEPTH).
  - a typedef for the stack command encoding {IDLE, PUSH, POP, TOS, ILLEGAL} used by the decode.
- Sub-module `stack_regfile`: one synchronous write port and one combinational read port, addressed by `sp` / `sp-1`.
- `stack_unit` owns command decode, the pointer, the flags and the `d_out` register.

## Test plan
- **Reset then pop:** `rst` low 2 cycles, then `pop` → `udf` = 1, `d_valid` = 0, `d_out` = 0, `count` = 0.
- **LIFO order:** push 0x11, 0x22, 0x33, then pop ×3 → `d_out` = 0x33, 0x22, 0x11 on consecutive cycles, `d_valid` high each cycle, `empty` = 1 at the end.
- **Fill and overflow** (DEPTH = 8): push 0x01–0x08, then push 0xFF → `full` = 1, `ovf` = 1, `count` = 8; tos → `d_out` = 0x08.
- **tos non-destructive:** push 0x5A, tos ×2 → `d_out` = 0x5A twice, `count` stays 1.
- **Illegal command:** with 0x44 on the stack, assert `push` + `pop` with `d_in` = 0x99 → `cmd_err` = 1, `count` = 1; a following tos returns 0x44.
- **Reset mid-operation:** push 3 words, assert `rst` together with `pop` → `count` = 0, `d_valid` = 0, all flags 0; a push of 0x07 then tos returns 0x07.
